// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The oldest entry is always presented on r_data so a consumer can inspect it
// before deciding to pop. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty,
    output logic [DEPTH:0]   count
);

    localparam int unsigned ENTRIES = 1 << DEPTH;
    localparam int unsigned PW      = DEPTH + 1;

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic             push_c;
    logic             pop_c;

    // Accept rules; a push while full is dropped even if a pop happens alongside.
    always_comb begin
        push_c = w_en && !full;
        pop_c  = r_en && !empty;
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (push_c) begin
            wp_d = wp_q + PW'(1);
        end
        if (pop_c) begin
            rp_d = rp_q + PW'(1);
        end
    end

    // Pointer registers, cleared immediately by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge aclk) begin
        if (push_c) begin
            mem_q[wp_q[DEPTH-1:0]] <= w_data;
        end
    end

    // Status and front-entry view, derived only from registered state.
    always_comb begin
        count  = wp_q - rp_q;
        empty  = (wp_q == rp_q);
        full   = (wp_q[DEPTH] != rp_q[DEPTH]) &&
                 (wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]);
        r_data = mem_q[rp_q[DEPTH-1:0]];
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo at default parameters.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned CAP   = 1 << DEPTH;

    logic             aclk;
    logic             aresetn;
    logic             w_en;
    logic [WIDTH-1:0] w_data;
    logic             r_en;
    logic [WIDTH-1:0] r_data;
    logic             full;
    logic             empty;
    logic [DEPTH:0]   count;

    int n_tests;
    int n_fail;
    logic [WIDTH-1:0] sb [$];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .w_en    (w_en),
        .w_data  (w_data),
        .r_en    (r_en),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare status outputs against the scoreboard occupancy.
    task automatic check_flags(input string tag);
        check_eq({tag, "_count"}, 64'(count), 64'(sb.size()));
        check_eq({tag, "_empty"}, 64'(empty), 64'(sb.size() == 0));
        check_eq({tag, "_full"},  64'(full),  64'(sb.size() == CAP));
    endtask

    // One clock: drive inputs, check popped word, update model after the edge.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
        logic push_ok;
        logic pop_ok;
        w_en    = w;
        w_data  = d;
        r_en    = r;
        push_ok = w && (sb.size() < CAP);
        pop_ok  = r && (sb.size() > 0);
        if (pop_ok) begin
            check_eq({tag, "_rdata"}, 64'(r_data), 64'(sb[0]));
        end
        @(posedge aclk);
        #1;
        if (pop_ok) begin
            void'(sb.pop_front());
        end
        if (push_ok) begin
            sb.push_back(d);
        end
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        w_data  = '0;
        aresetn = 1'b0;
        #12;
        check_flags("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Pop while empty is ignored.
        cycle(1'b0, '0, 1'b1, "idle_pop");
        check_flags("idle_pop");

        // Fall-through of a single word.
        cycle(1'b1, 32'h1111_1111, 1'b0, "single");
        check_flags("single_push");
        check_eq("single_fwft", 64'(r_data), 64'h1111_1111);
        cycle(1'b0, '0, 1'b1, "single_pop");
        check_flags("single_pop");

        // Push while empty with r_en: push accepted, pop ignored.
        cycle(1'b1, 32'hA5A5_0001, 1'b1, "empty_wr");
        check_flags("empty_wr");
        check_eq("empty_wr_data", 64'(r_data), 64'hA5A5_0001);
        cycle(1'b0, '0, 1'b1, "empty_wr_drain");
        check_flags("empty_wr_drain");

        // Fill to capacity.
        for (int i = 0; i < int'(CAP); i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, "fill");
        end
        check_flags("filled");
        check_eq("filled_count", 64'(count), 64'(CAP));
        cycle(1'b1, 32'h0000_DEAD, 1'b0, "drop");
        check_flags("drop");

        // Drain in order.
        for (int i = 0; i < int'(CAP); i++) begin
            check_eq("drain_order", 64'(r_data), 64'(i));
            cycle(1'b0, '0, 1'b1, "drain");
        end
        check_flags("drained");

        // Refill, then simultaneous push/pop while full: pop only.
        for (int i = 0; i < int'(CAP); i++) begin
            cycle(1'b1, WIDTH'(32'h100 + i), 1'b0, "refill");
        end
        cycle(1'b1, 32'hBEEF_0000, 1'b1, "full_wr");
        check_flags("full_wr");
        check_eq("full_wr_count", 64'(count), 64'(CAP - 1));
        cycle(1'b1, 32'hBEEF_0001, 1'b1, "both");
        check_flags("both");
        check_eq("both_count", 64'(count), 64'(CAP - 1));
        while (sb.size() > 0) begin
            cycle(1'b0, '0, 1'b1, "drain2");
        end
        check_flags("drained2");

        // Random traffic: 100 words through, wrapping the pointers.
        begin
            int pushed;
            int budget;
            pushed = 0;
            budget = 0;
            while ((pushed < 100 || sb.size() > 0) && budget < 3000) begin
                logic w;
                logic r;
                logic [WIDTH-1:0] d;
                w = (pushed < 100) && ($urandom_range(0, 99) < 60);
                r = ($urandom_range(0, 99) < 50);
                d = $urandom;
                if (w && sb.size() < CAP) begin
                    pushed++;
                end
                cycle(w, d, r, "rand");
                check_eq("rand_count", 64'(count), 64'(sb.size()));
                budget++;
            end
            if (budget >= 3000) begin
                check_eq("rand_budget", 64'(budget), 64'(0));
            end
        end
        check_flags("rand_end");

        // Async reset mid-cycle with 7 entries.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, WIDTH'(32'h700 + i), 1'b0, "pre_rst");
        end
        check_eq("pre_rst_count", 64'(count), 64'd7);
        #2;
        aresetn = 1'b0;
        sb.delete();
        #1;
        check_flags("async_rst");
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_flags("post_rst_idle");
        cycle(1'b1, 32'hCAFE_F00D, 1'b0, "post_rst");
        check_flags("post_rst_push");
        check_eq("post_rst_data", 64'(r_data), 64'hCAFE_F00D);
        cycle(1'b0, '0, 1'b1, "post_rst_pop");
        check_flags("post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous first-word-fall-through FIFO that buffers fixed-width words between a producer and a consumer in one clock domain. The front entry is always visible on `r_data`, so a consumer can decode it before deciding to pop. Its first user is the accelerator's 32-bit instruction queue: a bus-side writer pushes instruction words and the instruction decoder peeks at and pops them.

## Interface
Parameters:
- `WIDTH`, default 32: word width in bits.
- `DEPTH`, default 5: address width. Capacity is 2^DEPTH entries (32 at default).

Ports (one clock; reset is asynchronous and active-low):
- `aclk` input 1: clock. All state updates on its rising edge.
- `aresetn` input 1: asynchronous active-low reset.
- `w_en` input 1: push request.
- `w_data` input WIDTH: word to push.
- `r_en` input 1: pop request.
- `r_data` output WIDTH: front (oldest) entry, combinational.
- `full` output 1: FIFO holds 2^DEPTH entries.
- `empty` output 1: FIFO holds 0 entries.
- `count` output DEPTH+1: current occupancy, 0 to 2^DEPTH.

## Operation
Storage and pointers:
- Storage is an array of 2^DEPTH words of WIDTH bits. Storage contents are not reset.
- Write pointer `wp` and read pointer `rp` are each DEPTH+1 bits wide. Storage is indexed by the low DEPTH bits.
- Pointers wrap naturally modulo 2^(DEPTH+1).

Push and pop rules:
- A push is accepted iff `w_en && !full`. On acceptance, `mem[wp]` is set to `w_data` and `wp` increments by 1.
- A pop is accepted iff `r_en && !empty`. On acceptance, `rp` increments by 1. Nothing is cleared.
- A push while full is silently dropped, even if a pop happens in the same cycle. No state changes from the dropped push.
- A pop while empty is ignored.
- Simultaneous accepted push and pop: both pointers advance and `count` is unchanged.
- Push while empty together with `r_en`: the push is accepted and the pop is ignored. The word becomes visible next cycle.

Derived outputs:
- `count = wp - rp` (DEPTH+1-bit subtraction).
- `empty = (wp == rp)`.
- `full = (wp[DEPTH] != rp[DEPTH]) && (wp[DEPTH-1:0] == rp[DEPTH-1:0])`.
- `r_data = mem[rp[DEPTH-1:0]]` at all times. It is meaningful only when `!empty`; consumers must qualify it with `empty`.

Data integrity:
- Words are read in strict push order.
- No word is lost or duplicated across pointer wrap-around.

## Timing
Reset:
- Asserting `aresetn` low immediately, without waiting for a clock edge, sets `wp = rp = 0`. This gives `empty = 1`, `full = 0`, `count = 0`.
- Reset mid-operation discards all contents.
- `r_data` is undefined after reset until the first push.

Push-to-read latency:
- A push accepted at edge N makes `empty` fall and `r_data` show the word right after edge N.
- So a pop is possible on the cycle ending at edge N+1.

Pop behaviour:
- A pop at edge N exposes the next entry on `r_data` right after edge N.
- A consumer may therefore pop one word per cycle back to back.

Flags:
- `full`, `empty` and `count` depend only on the registered pointers. They update only on clock edges or on reset.
- No output has a combinational path from any input (`w_en`, `r_en` or `w_data`). `r_data` changes only through pointer and storage updates at clock edges.

Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset then idle: `empty = 1`, `full = 0`, `count = 0`. Pulse `r_en` while empty: pointers unchanged, `count` stays 0.
- Push 0x11111111 at edge 1: after edge 1, `empty = 0`, `count = 1`, `r_data = 0x11111111` (fall-through). Pop at edge 2: `empty = 1` again.
- Fill: push 0..31 (DEPTH = 5). After the 32nd push, `full = 1` and `count = 32`. A further push of 0xDEAD is dropped. Drain 32 pops and check the values read are 0..31 in order, ending with `empty = 1`.
- Full plus simultaneous `w_en`/`r_en`: only the pop happens, so `count` becomes 31 and `full` falls. On the next cycle a simultaneous push and pop keeps `count` at 31.
- Wrap-around: run 100 words through with random push/pop activity and occupancy at most 32. The scoreboard matches every word in order, and `count` equals pushes minus pops every cycle.
- Asynchronous reset asserted mid-cycle with `count = 7`: `empty = 1` and `count = 0` before the next edge. Later pushes behave as from power-up.
